// File: rtl/sprite_compositor.sv
// sprite_compositor: 3-stage pixel compositor layering prioritised sprites, a blinking pellet grid
// and the board background; sprite/pellet state is shadowed once per frame on frame_start.
module sprite_compositor #(
    parameter int NUM_SPRITES  = 5,
    parameter int SPRITE_W     = 26,
    parameter int SEL_W        = 3,
    parameter int ADDR_W       = 13,
    parameter int GRID_COLS    = 28,
    parameter int GRID_ROWS    = 31,
    parameter int CELL         = 15,
    parameter int ORG_X        = 110,
    parameter int ORG_Y        = 8,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                             vga_clk,
    input  logic                             reset,
    input  logic [9:0]                       DrawX,
    input  logic [9:0]                       DrawY,
    input  logic                             blank,
    input  logic                             frame_start,
    input  logic [NUM_SPRITES*32-1:0]        sprite_x,
    input  logic [NUM_SPRITES*32-1:0]        sprite_y,
    input  logic [NUM_SPRITES*SEL_W-1:0]     sprite_sel,
    input  logic [NUM_SPRITES-1:0]           sprite_en,
    input  logic [GRID_ROWS*GRID_COLS-1:0]   pellets,
    input  logic [GRID_ROWS*GRID_COLS-1:0]   power_mask,
    input  logic [11:0]                      board_rgb,
    output logic [NUM_SPRITES*ADDR_W-1:0]    rom_addr,
    input  logic [NUM_SPRITES*13-1:0]        rom_q,
    output logic [3:0]                       red,
    output logic [3:0]                       green,
    output logic [3:0]                       blue
);
    localparam int NCELL = GRID_ROWS * GRID_COLS;
    localparam int IDX_W = $clog2(NCELL);
    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);

    logic [NUM_SPRITES*32-1:0]    sx_q, sy_q, sx, sy;
    logic [NUM_SPRITES*SEL_W-1:0] ssel_q, ssel;
    logic [NUM_SPRITES-1:0]       sen_q, sen;
    logic [NCELL-1:0]             pel_q, pow_q, pel, pow;
    logic [CNT_W-1:0]             cnt_q;
    logic                         blink_q;

    // A pixel arriving with frame_start must already see the freshly latched state
    assign sx   = frame_start ? sprite_x   : sx_q;
    assign sy   = frame_start ? sprite_y   : sy_q;
    assign ssel = frame_start ? sprite_sel : ssel_q;
    assign sen  = frame_start ? sprite_en  : sen_q;
    assign pel  = frame_start ? pellets    : pel_q;
    assign pow  = frame_start ? power_mask : pow_q;

    logic [NUM_SPRITES-1:0]        hit_d;
    logic [NUM_SPRITES*ADDR_W-1:0] addr_d;

    genvar i;
    for (i = 0; i < NUM_SPRITES; i++) begin : g_spr
        logic [32:0] xs, ys, xp, yp;
        logic [31:0] dx, dy, a;
        assign xs = {1'b0, sx[32*i +: 32]};
        assign ys = {1'b0, sy[32*i +: 32]};
        assign xp = 33'(DrawX);
        assign yp = 33'(DrawY);
        assign hit_d[i] = sen[i] && xp >= xs && xp < xs + 33'(SPRITE_W)
                        && yp >= ys && yp < ys + 33'(SPRITE_W);
        assign dx = 32'(xp - xs);
        assign dy = 32'(yp - ys);
        assign a  = 32'(ssel[SEL_W*i +: SEL_W]) * 32'(SPRITE_W * SPRITE_W) + dy * 32'(SPRITE_W) + dx;
        assign addr_d[ADDR_W*i +: ADDR_W] = hit_d[i] ? a[ADDR_W-1:0] : '0;
    end

    logic             in_board, pel_d, pow_d;
    logic [9:0]       ox, oy, col, row, cx, cy;
    logic [IDX_W-1:0] idx;

    assign in_board = DrawX >= 10'(ORG_X) && DrawX < 10'(ORG_X + GRID_COLS * CELL)
                   && DrawY >= 10'(ORG_Y) && DrawY < 10'(ORG_Y + GRID_ROWS * CELL);
    assign ox  = DrawX - 10'(ORG_X);
    assign oy  = DrawY - 10'(ORG_Y);
    assign col = ox / 10'(CELL);
    assign row = oy / 10'(CELL);
    assign cx  = ox % 10'(CELL);
    assign cy  = oy % 10'(CELL);
    assign idx = in_board ? IDX_W'(32'(row) * 32'(GRID_COLS) + 32'(col)) : '0;
    assign pel_d = in_board && cx >= 10'd6 && cx <= 10'd8 && cy >= 10'd6 && cy <= 10'd8 && pel[idx];
    assign pow_d = pow[idx];

    logic [NUM_SPRITES*ADDR_W-1:0] rom_addr_q;
    logic [NUM_SPRITES-1:0]        hit1_q, hit2_q;
    logic                          pel1_q, pow1_q, blank1_q, pel2_q, blank2_q;
    logic [11:0]                   board1_q, board2_q, rgb_d, rgb_q;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            sx_q       <= '0;
            sy_q       <= '0;
            ssel_q     <= '0;
            sen_q      <= '0;
            pel_q      <= '0;
            pow_q      <= '0;
            cnt_q      <= '0;
            blink_q    <= 1'b1;
            rom_addr_q <= '0;
            hit1_q     <= '0;
            pel1_q     <= 1'b0;
            pow1_q     <= 1'b0;
            blank1_q   <= 1'b0;
            board1_q   <= '0;
            hit2_q     <= '0;
            pel2_q     <= 1'b0;
            blank2_q   <= 1'b0;
            board2_q   <= '0;
            rgb_q      <= '0;
        end else begin
            if (frame_start) begin
                sx_q    <= sprite_x;
                sy_q    <= sprite_y;
                ssel_q  <= sprite_sel;
                sen_q   <= sprite_en;
                pel_q   <= pellets;
                pow_q   <= power_mask;
                cnt_q   <= (cnt_q == CNT_W'(BLINK_FRAMES - 1)) ? '0 : cnt_q + 1'b1;
                blink_q <= (cnt_q == CNT_W'(BLINK_FRAMES - 1)) ? ~blink_q : blink_q;
            end
            rom_addr_q <= addr_d;
            hit1_q     <= hit_d;
            pel1_q     <= pel_d;
            pow1_q     <= pow_d;
            blank1_q   <= blank;
            board1_q   <= board_rgb;
            hit2_q     <= hit1_q;
            pel2_q     <= pel1_q && (!pow1_q || blink_q);
            blank2_q   <= blank1_q;
            board2_q   <= board1_q;
            rgb_q      <= rgb_d;
        end
    end

    // Walk from lowest priority upwards so sprite 0 overrides everything
    always_comb begin
        rgb_d = pel2_q ? 12'hFFF : board2_q;
        for (int k = NUM_SPRITES - 1; k >= 0; k--)
            if (hit2_q[k] && rom_q[13*k+12]) rgb_d = rom_q[13*k +: 12];
        if (!blank2_q) rgb_d = '0;
    end

    assign rom_addr = rom_addr_q;
    assign red      = rgb_q[11:8];
    assign green    = rgb_q[7:4];
    assign blue     = rgb_q[3:0];
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed vector table plus hand sequences for shadowing, blink and reset.
module tb_sprite_compositor;
    localparam int NS = 5;
    localparam int NC = 31 * 28;

    logic            vga_clk = 1'b0;
    logic            reset;
    logic [9:0]      DrawX, DrawY;
    logic            blank, frame_start;
    logic [NS*32-1:0] sprite_x, sprite_y;
    logic [NS*3-1:0] sprite_sel;
    logic [NS-1:0]   sprite_en;
    logic [NC-1:0]   pellets, power_mask;
    logic [11:0]     board_rgb;
    logic [NS*13-1:0] rom_addr;
    logic [NS*13-1:0] rom_q = '0;
    logic [3:0]      red, green, blue;

    logic [11:0] rom_col [NS];
    logic        rom_op  [NS];
    int ncmp = 0, nerr = 0, nfs = 0;

    sprite_compositor dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .frame_start(frame_start), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .sprite_sel(sprite_sel), .sprite_en(sprite_en), .pellets(pellets),
        .power_mask(power_mask), .board_rgb(board_rgb), .rom_addr(rom_addr),
        .rom_q(rom_q), .red(red), .green(green), .blue(blue)
    );

    always #5 vga_clk = ~vga_clk;

    // Synchronous ROM model: data one cycle after address, per-sprite colour/opacity
    always @(posedge vga_clk)
        for (int s = 0; s < NS; s++) rom_q[13*s +: 13] <= {rom_op[s], rom_col[s]};

    typedef struct {
        logic [9:0]  x, y;
        logic        b;
        logic [11:0] bd, exp;
    } vec_t;
    vec_t tv[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic px(input logic [9:0] x, input logic [9:0] y, input logic b, input logic [11:0] bd);
        DrawX = x; DrawY = y; blank = b; board_rgb = bd;
        repeat (3) @(posedge vga_clk);
        #1;
    endtask

    task automatic frame();
        frame_start = 1'b1; blank = 1'b0;
        @(posedge vga_clk); #1;
        frame_start = 1'b0;
        nfs++;
    endtask

    initial begin
        reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0; frame_start = 1'b0;
        sprite_x = '0; sprite_y = '0; sprite_sel = '0; sprite_en = '0;
        pellets = '0; power_mask = '0; board_rgb = '0;
        for (int s = 0; s < NS; s++) begin rom_col[s] = 12'h000; rom_op[s] = 1'b1; end
        rom_col[0] = 12'hF00; rom_col[1] = 12'h0F0;
        tv[0]  = '{10'd100, 10'd50, 1'b1, 12'h123, 12'hF00};
        tv[1]  = '{10'd99,  10'd50, 1'b1, 12'h234, 12'h234};
        tv[2]  = '{10'd126, 10'd50, 1'b1, 12'h345, 12'h345};
        tv[3]  = '{10'd125, 10'd75, 1'b1, 12'h456, 12'hF00};
        tv[4]  = '{10'd125, 10'd76, 1'b1, 12'h567, 12'h567};
        tv[5]  = '{10'd147, 10'd30, 1'b1, 12'h678, 12'hFFF};
        tv[6]  = '{10'd145, 10'd30, 1'b1, 12'h789, 12'h789};
        tv[7]  = '{10'd146, 10'd29, 1'b1, 12'h89A, 12'hFFF};
        tv[8]  = '{10'd148, 10'd31, 1'b1, 12'h9AB, 12'hFFF};
        tv[9]  = '{10'd149, 10'd30, 1'b1, 12'hABC, 12'hABC};
        tv[10] = '{10'd100, 10'd50, 1'b0, 12'hBCD, 12'h000};
        tv[11] = '{10'd117, 10'd15, 1'b1, 12'hCDE, 12'hFFF};
        tv[12] = '{10'd102, 10'd15, 1'b1, 12'hDEF, 12'hDEF};

        repeat (3) @(posedge vga_clk); #1;
        chk("reset_rgb", {20'd0, red, green, blue}, 32'h0);
        chk("reset_addr0", {19'd0, rom_addr[12:0]}, 32'h0);
        reset = 1'b0;

        sprite_x[0 +: 32] = 32'd100; sprite_y[0 +: 32] = 32'd50; sprite_en[0] = 1'b1;
        pellets[1*28+2] = 1'b1; pellets[0] = 1'b1;
        frame();
        DrawX = 10'd101; DrawY = 10'd51; blank = 1'b1;
        @(posedge vga_clk); #1;
        chk("addr0_101_51", {19'd0, rom_addr[12:0]}, 32'd27);

        for (int v = 0; v < 13; v++) begin
            px(tv[v].x, tv[v].y, tv[v].b, tv[v].bd);
            chk($sformatf("vec%0d", v), {20'd0, red, green, blue}, {20'd0, tv[v].exp});
        end

        sprite_x[0 +: 32] = 32'd190; sprite_y[0 +: 32] = 32'd190;
        sprite_x[32 +: 32] = 32'd180; sprite_y[32 +: 32] = 32'd185;
        sprite_sel[3 +: 3] = 3'd1; sprite_en[1] = 1'b1;
        frame();
        DrawX = 10'd200; DrawY = 10'd200; blank = 1'b1; board_rgb = 12'h321;
        @(posedge vga_clk); #1;
        chk("addr0_overlap", {19'd0, rom_addr[12:0]}, 32'd270);
        chk("addr1_overlap", {19'd0, rom_addr[25:13]}, 32'd1086);
        px(10'd200, 10'd200, 1'b1, 12'h321);
        chk("overlap_s0", {20'd0, red, green, blue}, 32'hF00);
        rom_op[0] = 1'b0;
        px(10'd200, 10'd200, 1'b1, 12'h321);
        chk("s0_transparent", {20'd0, red, green, blue}, 32'h0F0);
        rom_op[0] = 1'b1; sprite_en[0] = 1'b0;
        px(10'd200, 10'd200, 1'b1, 12'h321);
        chk("en_shadowed", {20'd0, red, green, blue}, 32'hF00);
        frame();
        px(10'd200, 10'd200, 1'b1, 12'h321);
        chk("s0_disabled", {20'd0, red, green, blue}, 32'h0F0);

        pellets[30] = 1'b0;
        px(10'd147, 10'd30, 1'b1, 12'h444);
        chk("pellet_shadowed", {20'd0, red, green, blue}, 32'hFFF);
        frame();
        px(10'd147, 10'd30, 1'b1, 12'h444);
        chk("pellet_cleared", {20'd0, red, green, blue}, 32'h444);

        pellets[30] = 1'b1;
        DrawX = 10'd147; DrawY = 10'd30; blank = 1'b1; board_rgb = 12'h111; frame_start = 1'b1;
        @(posedge vga_clk); #1;
        frame_start = 1'b0; blank = 1'b0; nfs++;
        repeat (2) @(posedge vga_clk); #1;
        chk("same_cycle_latch", {20'd0, red, green, blue}, 32'hFFF);

        reset = 1'b1;
        @(posedge vga_clk); #1;
        reset = 1'b0; nfs = 0;
        power_mask[30] = 1'b1;
        px(10'd147, 10'd30, 1'b1, 12'hABC);
        chk("post_reset_shadow", {20'd0, red, green, blue}, 32'hABC);
        for (int p = 1; p <= 48; p++) begin
            frame();
            if (p == 1 || p == 15 || p == 16 || p == 17 || p == 31 || p == 32 || p == 47 || p == 48) begin
                px(10'd147, 10'd30, 1'b1, 12'hABC);
                chk($sformatf("blink_p%0d", nfs), {20'd0, red, green, blue},
                    ((nfs / 16) % 2 == 0) ? 32'hFFF : 32'hABC);
            end
        end

        reset = 1'b1;
        #2;
        chk("async_reset_rgb", {20'd0, red, green, blue}, 32'h0);
        @(posedge vga_clk); #1;
        reset = 1'b0; nfs = 0;
        frame();
        px(10'd147, 10'd30, 1'b1, 12'hABC);
        chk("blink_after_reset", {20'd0, red, green, blue}, 32'hFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised pixel compositor that replaces the single-sprite mapper.
- Overlays NUM_SPRITES sprites (Pac-Man plus ghosts) with fixed priority, a pellet grid with blinking power pellets, and the board background.
- Fixed-latency pipeline in the vga_clk domain, between the VGA timing generator and the HDMI encoder.
- Sprite and pellet state is latched once per frame so that CPU writes never tear a frame.

Parameters:
- NUM_SPRITES, 5, number of sprite channels; index 0 has the highest priority.
- SPRITE_W, 26, sprite width and height in pixels.
- SEL_W, 3, width of the per-sprite tile select.
- ADDR_W, 13, sprite ROM address width.
- GRID_COLS, 28, pellet grid columns.
- GRID_ROWS, 31, pellet grid rows.
- CELL, 15, cell size in pixels.
- ORG_X, 110, board origin X in pixels.
- ORG_Y, 8, board origin Y in pixels.
- BLINK_FRAMES, 16, number of frames per power-pellet blink phase.

Ports:
- vga_clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- blank  in  1  1 = visible pixel.
- frame_start  in  1  one-cycle pulse before the first visible line.
- sprite_x  in  NUM_SPRITES*32  sprite top-left X, sprite i at bits [32i+31:32i].
- sprite_y  in  NUM_SPRITES*32  sprite top-left Y.
- sprite_sel  in  NUM_SPRITES*SEL_W  tile (frame/direction) select.
- sprite_en  in  NUM_SPRITES  per-sprite enable.
- pellets  in  GRID_ROWS*GRID_COLS  pellet present, bit r*GRID_COLS+c.
- power_mask  in  GRID_ROWS*GRID_COLS  1 = that cell's pellet blinks.
- board_rgb  in  12  background colour for the current DrawX/DrawY, same cycle.
- rom_addr  out  NUM_SPRITES*ADDR_W  per-sprite ROM address.
- rom_q  in  NUM_SPRITES*13  per-sprite ROM data one cycle after rom_addr: bit 12 = opaque, bits [11:0] = RGB.
- red  out  4  output red.
- green  out  4  output green.
- blue  out  4  output blue.

Behaviour:
- Reset (async, active-high) clears:
  - red, green, blue and rom_addr to 0;
  - all shadow registers and pipeline registers;
  - the frame counter;
  - blink_on, which resets to 1.
- Shadow latch: on a frame_start cycle, all sprite_*, pellets and power_mask inputs are copied into shadow registers. All rendering uses only the shadow copies. Input changes outside frame_start have no effect until the next frame_start.
- Blink:
  - frame_cnt increments on each frame_start.
  - When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
  - Blink counting uses the frame_start pulse, so its updates take effect from the frame started by that pulse.
- Pipeline, fixed latency 3 cycles from DrawX/DrawY/blank/board_rgb to red/green/blue:
  - S1: register the pixel inputs. Per sprite, hit_i = en_i && DrawX >= x_i && DrawX < x_i+SPRITE_W && DrawY >= y_i && DrawY < y_i+SPRITE_W, compared at 32 bits with no wrap. rom_addr_i = sel_i*SPRITE_W*SPRITE_W + (DrawY-y_i)*SPRITE_W + (DrawX-x_i), or 0 when there is no hit. Compute the pellet grid cell, col/row = offset / CELL, and the in-cell position = offset % CELL.
  - S2: rom_q is valid. Pellet pixel = inside board && in-cell position in [6,8] on both axes && pellet bit && (!power_bit || blink_on).
  - S3: register the output.
- Output priority, highest first:
  - !blank gives 0.
  - The lowest-index sprite with hit && opaque gives its RGB.
  - A pellet pixel gives 0xFFF.
  - Otherwise board_rgb.
- A transparent sprite pixel falls through to the next layer.
- Pixels outside the board rectangle never draw pellets.
- The pipeline accepts a new pixel every cycle and never stalls. blank is delayed through all three stages alongside the data.
- If frame_start and a visible pixel arrive in the same cycle, that pixel already uses the newly latched values.
- Reset mid-frame: outputs go to 0 immediately. The first valid output appears 3 cycles after reset deasserts and after the next frame_start.

Test Plan:
- Reset, then pulse frame_start with sprite 0 enabled at (100,50), sel=0, and the ROM model all opaque 0xF00 -> pixel (100,50) outputs 0xF00 3 cycles later. Pixel (99,50) and pixel (126,50) output board_rgb. rom_addr0 at (101,51) = 27.
- Sprites 0 and 1 overlap at (200,200) -> sprite 0's colour wins. With sprite 0 transparent at that pixel, sprite 1's colour wins. With sprite_en[0]=0, sprite 1 always wins.
- Pellet at row 1, col 2 -> pixel (110+30+7, 8+15+7) outputs 0xFFF. Pixel (110+30+5, 8+15+7) outputs board_rgb. Clearing the pellet bit mid-frame has no effect until the next frame_start.
- Set the power bit for cell (1,2) with BLINK_FRAMES=16 -> the pellet is visible for frames 0–15, hidden for frames 16–31, and visible again from frame 32.
- Hold blank=0 while a sprite is hit -> output 0. Assert reset mid-line -> red/green/blue go to 0 asynchronously and blink_on returns to 1.
